// File: rtl/sort_pkg.sv
// Shared definitions for the insertion-sort controller: default sizes, count width, state and cell op encodings.
package sort_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned DEPTH_DEF = 8;
    localparam int unsigned CNT_W_DEF = $clog2(DEPTH_DEF + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_LOWER = 2'd2,
        OP_UPPER = 2'd3
    } cell_op_e;

endpackage

// File: rtl/sort_cell.sv
// One slot of the ascending key array: holds a key, compares it with the incoming key
// and picks hold / load-new / take-lower-neighbour / take-upper-neighbour.
module sort_cell
    import sort_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             insert,
    input  logic             shift,
    input  logic             occupied,
    input  logic             lower_disp,
    input  logic [WIDTH-1:0] new_key,
    input  logic [WIDTH-1:0] lower_key,
    input  logic [WIDTH-1:0] upper_key,
    output logic [WIDTH-1:0] key,
    output logic             disp_c
);

    cell_op_e op;

    // Strictly-greater keeps equal keys ahead of the new one; empty slots always yield.
    assign disp_c = !occupied || (key > new_key);

    always_comb begin
        op = OP_HOLD;
        if (insert && disp_c) begin
            op = lower_disp ? OP_LOWER : OP_LOAD;
        end else if (shift) begin
            op = OP_UPPER;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            key <= '0;
        end else begin
            unique case (op)
                OP_LOAD:  key <= new_key;
                OP_LOWER: key <= lower_key;
                OP_UPPER: key <= upper_key;
                default:  key <= key;
            endcase
        end
    end

endmodule

// File: rtl/sort_ctrl.sv
// Frame-based insertion sorter: loads keys into a sorted cell array, then drains them smallest first.
module sort_ctrl
    import sort_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_last,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] count_q;
    logic             in_acc;
    logic             out_acc;
    logic             last_slot;

    logic [WIDTH-1:0] key_arr [DEPTH];
    logic             disp    [DEPTH];

    assign in_ready  = reset && ((state_q == IDLE) || (state_q == LOAD));
    assign out_valid = (state_q == DRAIN);
    assign in_acc    = in_valid && in_ready;
    assign out_acc   = out_valid && out_ready;
    assign last_slot = (count_q == CNT_W'(DEPTH - 1));

    assign out_data  = key_arr[0];
    assign out_last  = out_valid && (count_q == CNT_W'(1));
    assign busy      = (state_q != IDLE);
    assign count     = count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, LOAD: begin
                if (in_acc) begin
                    state_d = (in_last || last_slot) ? DRAIN : LOAD;
                end
            end
            DRAIN: begin
                if (out_acc && (count_q == CNT_W'(1))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Input and output accepts live in disjoint states, so they never coincide.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else if (in_acc) begin
            count_q <= count_q + CNT_W'(1);
        end else if (out_acc) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        logic             lower_disp;
        logic [WIDTH-1:0] lower_key;
        logic [WIDTH-1:0] upper_key;

        if (i == 0) begin : g_bottom
            assign lower_disp = 1'b0;
            assign lower_key  = '0;
        end else begin : g_lower
            assign lower_disp = disp[i-1];
            assign lower_key  = key_arr[i-1];
        end

        if (i == DEPTH - 1) begin : g_top
            assign upper_key = '0;
        end else begin : g_upper
            assign upper_key = key_arr[i+1];
        end

        sort_cell #(
            .WIDTH(WIDTH)
        ) u_cell (
            .clk        (clk),
            .reset      (reset),
            .insert     (in_acc),
            .shift      (out_acc),
            .occupied   (CNT_W'(i) < count_q),
            .lower_disp (lower_disp),
            .new_key    (in_data),
            .lower_key  (lower_key),
            .upper_key  (upper_key),
            .key        (key_arr[i]),
            .disp_c     (disp[i])
        );
    end

endmodule

// File: tb/tb_sort_ctrl.sv
// Scoreboard bench for sort_ctrl: expected sorted frames are queued when driven and checked as keys drain.
module tb_sort_ctrl;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic [3:0] count;

    exp_t sb[$];
    int   frame[$];
    int   total = 0;
    int   bad = 0;
    bit   stall_mode = 1'b0;
    bit   pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int   ph = 0;

    sort_ctrl #(.WIDTH(8), .DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sort a copy of the current frame and queue the expected beats.
    task automatic push_frame();
        int a[$];
        int t;
        a = frame;
        for (int i = 0; i < a.size(); i++) begin
            for (int j = 0; j + 1 < a.size() - i; j++) begin
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
            end
        end
        for (int i = 0; i < a.size(); i++) begin
            sb.push_back('{data: 8'(a[i]), last: (i == a.size() - 1)});
        end
    endtask

    task automatic send_key(input logic [7:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq("in_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_empty(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check_eq(tag, 32'(sb.size()), 32'd0);
        @(negedge clk);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check_eq({tag, "_count"}, 32'(count), 32'd0);
    endtask

    // Consumer back-pressure, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (stall_mode) begin
            out_ready = pat[ph];
            ph = (ph + 1) % 4;
        end else begin
            out_ready = 1'b1;
        end
    end

    // Output monitor: every valid beat (stalled or taken) must match the scoreboard head.
    always @(negedge clk) begin
        if (reset && out_valid) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                check_eq("out_data", 32'(out_data), 32'(sb[0].data));
                check_eq("out_last", 32'(out_last), 32'(sb[0].last));
                check_eq("out_count", 32'(count), 32'(sb.size()));
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset behaviour
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_out_last", 32'(out_last), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Full frame in descending order
        frame = '{100, 94, 54, 32, 24, 19, 14, 2};
        push_frame();
        for (int i = 0; i < 7; i++) send_key(8'(frame[i]), 1'b0);
        check_eq("t1_pre_valid", 32'(out_valid), 32'd0);
        check_eq("t1_pre_count", 32'(count), 32'd7);
        send_key(8'd2, 1'b1);
        check_eq("t1_first_valid", 32'(out_valid), 32'd1);
        check_eq("t1_first_data", 32'(out_data), 32'd2);
        wait_empty("t1");

        // Short frame terminated by in_last
        frame = '{7, 3, 5};
        push_frame();
        send_key(8'd7, 1'b0);
        check_eq("t2_busy_load", 32'(busy), 32'd1);
        send_key(8'd3, 1'b0);
        send_key(8'd5, 1'b1);
        check_eq("t2_count", 32'(count), 32'd3);
        check_eq("t2_in_ready_drain", 32'(in_ready), 32'd0);
        wait_empty("t2");

        // Overfull offer: DRAIN forced at DEPTH, ninth key waits for IDLE
        frame = '{200, 3, 77, 3, 150, 9, 0, 255};
        push_frame();
        for (int i = 0; i < 8; i++) send_key(8'(frame[i]), 1'b0);
        check_eq("t3_full_in_ready", 32'(in_ready), 32'd0);
        check_eq("t3_full_valid", 32'(out_valid), 32'd1);
        check_eq("t3_full_count", 32'(count), 32'd8);
        send_key(8'd42, 1'b0);
        check_eq("t3_ninth_after_drain", 32'(sb.size()), 32'd0);
        check_eq("t3_ninth_count", 32'(count), 32'd1);
        check_eq("t3_ninth_busy", 32'(busy), 32'd1);
        frame = '{42, 17};
        push_frame();
        send_key(8'd17, 1'b1);
        wait_empty("t3");

        // Duplicates with consumer stalls
        stall_mode = 1'b1;
        frame = '{5, 5, 1, 5};
        push_frame();
        for (int i = 0; i < 4; i++) send_key(8'(frame[i]), (i == 3));
        wait_empty("t4");
        stall_mode = 1'b0;

        // Reset in the middle of a load
        send_key(8'd30, 1'b0);
        send_key(8'd10, 1'b0);
        send_key(8'd20, 1'b0);
        check_eq("t5_pre_count", 32'(count), 32'd3);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("t5_count", 32'(count), 32'd0);
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_out_valid", 32'(out_valid), 32'd0);
        check_eq("t5_in_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        frame = '{4, 2};
        push_frame();
        send_key(8'd4, 1'b0);
        send_key(8'd2, 1'b1);
        wait_empty("t5");

        // Single-key frame at the top of the key range
        frame = '{255};
        push_frame();
        send_key(8'hFF, 1'b1);
        check_eq("t6_valid", 32'(out_valid), 32'd1);
        check_eq("t6_last", 32'(out_last), 32'd1);
        check_eq("t6_data", 32'(out_data), 32'hFF);
        wait_empty("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sort_ctrl.md
SORT_CTRL -- requirements
Module: sort_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 8, bit width of one sort key.
REQ-002 SHALL have parameter: DEPTH, 8, maximum keys per frame (>=2).
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: reset  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port: in_valid  input  1  key offered on in_data.
REQ-006 SHALL have port: in_ready  output  1  block accepts a key this cycle.
REQ-007 SHALL have port: in_data  input  WIDTH  unsigned key.
REQ-008 SHALL have port: in_last  input  1  qualifies the final key of a frame.
REQ-009 SHALL have port: out_valid  output  1  sorted key available.
REQ-010 SHALL have port: out_ready  input  1  consumer takes out_data this cycle.
REQ-011 SHALL have port: out_data  output  WIDTH  current smallest remaining key.
REQ-012 SHALL have port: out_last  output  1  out_data is the final key of the frame.
REQ-013 SHALL have port: busy  output  1  frame in progress (LOAD or DRAIN).
REQ-014 SHALL have port: count  output  clog2(DEPTH+1)  keys currently held.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, DRAIN; input accept = in_valid&&in_ready, output accept = out_valid&&out_ready.
REQ-016 SHALL assert in_ready in IDLE and LOAD only, and hold it 0 whenever reset is low.
REQ-017 SHALL, on each input accept, insert in_data into the ascending array within the same edge (parallel compare-and-shift), count+1.
REQ-018 SHALL place a key equal to held keys after them (stable; duplicates kept).
REQ-019 SHALL move IDLE->LOAD on an accept without in_last; IDLE or LOAD ->DRAIN on an accept with in_last or with count reaching DEPTH.
REQ-020 SHALL ignore in_last when in_valid is 0; a single-key frame (accept with in_last in IDLE) is legal.
REQ-021 SHALL assert out_valid exactly in DRAIN; first out_valid one cycle after the terminating input accept.
REQ-022 SHALL drive out_data = array[0]; on output accept shift array toward index 0, clear the vacated top entry to 0, count-1.
REQ-023 SHALL hold out_data/out_last stable while out_valid && !out_ready.
REQ-024 SHALL assert out_last when count==1 in DRAIN; its accept moves DRAIN->IDLE, in_ready=1 the next cycle.
REQ-025 SHALL assert busy in LOAD and DRAIN only.
REQ-026 SHALL ignore in_valid/in_data in DRAIN and out_ready outside DRAIN.
REQ-027 SHALL treat keys as unsigned; count never exceeds DEPTH nor wraps below 0.

Reset
REQ-028 SHALL, at a clk edge with reset low, enter IDLE, clear array and count to 0, regardless of state (mid-LOAD or mid-DRAIN frames discarded).
REQ-029 SHALL present after reset: in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0, count=0.

Structure
REQ-030 SHALL place WIDTH/DEPTH defaults, count width, and the state enumeration in shared package sort_pkg.
REQ-031 SHALL build the array from DEPTH instances of sub-module sort_cell (one key register, compare with new key, select hold/load-new/take-lower-neighbour/take-upper-neighbour).
REQ-032 SHALL keep the FSM, count and handshake logic in sort_ctrl; no combinational path from in_valid to out_valid.

Verification
REQ-033 SHALL cover: keys 100,94,54,32,24,19,14,2 (last on 2), out_ready=1 -> out 2,14,19,24,32,54,94,100; out_last on 100; out_valid first cycle after 2 accepted.
REQ-034 SHALL cover: frame 7,3,5 with in_last on 5 -> out 3,5,7, count 3->0, busy drops after 7 accepted, in_ready 1 next cycle.
REQ-035 SHALL cover: 9 keys offered, none with last, DEPTH=8 -> in_ready 0 after 8th accept, DRAIN of 8 sorted keys, 9th key accepted only after return to IDLE.
REQ-036 SHALL cover: keys 5,5,1,5 (last) with out_ready toggling 1,0,0,1 -> out 1,5,5,5, out_data stable across stalls, count decrements only on accepts.
REQ-037 SHALL cover: reset low for one edge after 3 keys loaded -> count=0, busy=0, out_valid=0; next frame 4,2 (last) -> out 2,4.
REQ-038 SHALL cover: single key 0xFF with in_last -> one beat out_data=0xFF, out_valid=1, out_last=1.
